// File: rtl/dec_stream_pkg.sv
// Shared types and the index-to-one-hot decode used by the streaming decoder.
package dec_stream_pkg;

    localparam int unsigned IDX_W_DEF = 3;

    typedef logic [7:0] onehot8_t;

    // A set none flag wins over idx and yields an all-zero word.
    function automatic onehot8_t onehot_decode(input logic [IDX_W_DEF-1:0] idx, input logic none);
        onehot8_t y;
        y = '0;
        if (!none) begin
            y[idx] = 1'b1;
        end
        return y;
    endfunction

endpackage

// File: rtl/sync_fifo_flop.sv
// Register-based FIFO. A popped slot is cleared, so an empty FIFO reads zero at the head.
module sync_fifo_flop #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push_i && (count_q != CNT_W'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        // Read and write slots differ whenever both fire, so clear-then-write is safe.
        if (do_pop) begin
            mem_d[rd_ptr_q] = '0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/dec_3_to_8_stream.sv
// Elastic index-to-one-hot decoder: decodes on push, buffers decoded words, valid/ready on both sides.
module dec_3_to_8_stream
    import dec_stream_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [IDX_W-1:0]           idx_i,
    input  logic                       none_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [(2**IDX_W)-1:0]      y_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned OUT_W = 2 ** IDX_W;

    logic [OUT_W-1:0] dec_word_c;
    logic             push_c;
    logic             pop_c;
    logic             full;
    logic             empty;

    if (IDX_W == IDX_W_DEF) begin : g_pkg_dec
        assign dec_word_c = OUT_W'(onehot_decode(idx_i, none_i));
    end else begin : g_gen_dec
        assign dec_word_c = none_i ? '0 : (OUT_W'(1) << idx_i);
    end

    // Handshake flags come only from registered occupancy; no path from ready_i to ready_o.
    assign ready_o = !full;
    assign valid_o = !empty;
    assign push_c  = valid_i && ready_o;
    assign pop_c   = valid_o && ready_i;

    sync_fifo_flop #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (dec_word_c),
        .rdata_o (y_o),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    a_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(y_o));
    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) count_o <= ($clog2(DEPTH+1))'(DEPTH));
    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i) (valid_o && !ready_i) |=> $stable(y_o));
    a_in_stable: assert property (@(posedge clk_i) disable iff (rst_i) (valid_i && !ready_o) |=> $stable({idx_i, none_i}));

endmodule

// File: tb/tb_dec_3_to_8_stream.sv
// Bench for dec_3_to_8_stream: directed scenarios plus a random run against a queue model.
module tb_dec_3_to_8_stream;

    localparam int unsigned DEPTH = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic       ready_o;
    logic [2:0] idx_i;
    logic       none_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] y_o;
    logic [1:0] count_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_q[$];

    always #5 clk_i = ~clk_i;

    dec_3_to_8_stream #(.IDX_W(3), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .idx_i   (idx_i),
        .none_i  (none_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .y_o     (y_o),
        .count_o (count_o)
    );

    // One clock edge; the model applies the transfer rules to the inputs seen at that edge.
    task automatic tick();
        bit push, pop;
        push = valid_i && (model_q.size() < DEPTH);
        pop  = ready_i && (model_q.size() != 0);
        @(posedge clk_i);
        if (rst_i) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(none_i ? 8'h00 : (8'h01 << idx_i));
        end
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; idx_i = 3'd0; none_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        n_checks++; if (y_o !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h expected 00", y_o); end
        n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_single();
        idx_i = 3'd5; none_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", valid_o); end
        n_checks++; if (y_o !== 8'b0010_0000) begin n_fail++; $display("FAIL single_y: got %h expected 20", y_o); end
        tick();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid: got %b expected 0", valid_o); end
        n_checks++; if (y_o !== 8'h00) begin n_fail++; $display("FAIL single_drain_y: got %h expected 00", y_o); end
    endtask

    task automatic test_none();
        idx_i = 3'd3; none_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0; none_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL none_valid: got %b expected 1", valid_o); end
        n_checks++; if (y_o !== 8'h00) begin n_fail++; $display("FAIL none_y: got %h expected 00", y_o); end
        tick();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL none_drain_valid: got %b expected 0", valid_o); end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0; valid_i = 1'b1; none_i = 1'b0;
        idx_i = 3'd1;
        tick();
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b expected 1", ready_o); end
        idx_i = 3'd2;
        tick();
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", ready_o); end
        n_checks++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL bp_count_full: got %0d expected 2", count_o); end
        idx_i = 3'd3;
        tick();
        n_checks++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL bp_refused: got %0d expected 2", count_o); end
        n_checks++; if (y_o !== 8'h02) begin n_fail++; $display("FAIL bp_y0: got %h expected 02", y_o); end
        ready_i = 1'b1;
        tick();
        n_checks++; if (y_o !== 8'h04) begin n_fail++; $display("FAIL bp_y1: got %h expected 04", y_o); end
        n_checks++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL bp_full_pop_no_push: got %0d expected 1", count_o); end
        tick();
        valid_i = 1'b0;
        n_checks++; if (y_o !== 8'h08) begin n_fail++; $display("FAIL bp_y2: got %h expected 08", y_o); end
        tick();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid: got %b expected 0", valid_o); end
    endtask

    task automatic test_back_to_back();
        valid_i = 1'b1; ready_i = 1'b1; none_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_y;
            exp_y = 8'h01 << i;
            idx_i = 3'(i);
            tick();
            n_checks++; if (y_o !== exp_y) begin n_fail++; $display("FAIL b2b_y[%0d]: got %h expected %h", i, y_o, exp_y); end
            n_checks++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 1", i, count_o); end
        end
        valid_i = 1'b0;
        tick();
        n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL b2b_drain: got %0d expected 0", count_o); end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0; valid_i = 1'b1; none_i = 1'b0;
        idx_i = 3'd4;
        tick();
        idx_i = 3'd6;
        tick();
        n_checks++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL rmid_fill: got %0d expected 2", count_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; valid_i = 1'b0;
        n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", count_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", valid_o); end
        n_checks++; if (y_o !== 8'h00) begin n_fail++; $display("FAIL rmid_y: got %h expected 00", y_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", ready_o); end
        idx_i = 3'd7; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        n_checks++; if (y_o !== 8'h80) begin n_fail++; $display("FAIL rmid_push7: got %h expected 80", y_o); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            bit         hold;
            logic [7:0] exp_y;
            hold = valid_i && (model_q.size() >= DEPTH);
            tick();
            exp_y = (model_q.size() != 0) ? model_q[0] : 8'h00;
            n_checks++; if (y_o !== exp_y) begin n_fail++; $display("FAIL rand_y cycle %0d: got %h expected %h", c, y_o, exp_y); end
            n_checks++; if (valid_o !== (model_q.size() != 0)) begin n_fail++; $display("FAIL rand_valid cycle %0d: got %b", c, valid_o); end
            n_checks++; if (count_o !== 2'(model_q.size())) begin n_fail++; $display("FAIL rand_count cycle %0d: got %0d expected %0d", c, count_o, model_q.size()); end
            n_checks++; if (ready_o !== (model_q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready cycle %0d: got %b", c, ready_o); end
            // A refused word must be offered again unchanged.
            if (!hold) begin
                valid_i = ($urandom_range(0, 3) != 0);
                idx_i   = 3'($urandom_range(0, 7));
                none_i  = ($urandom_range(0, 7) == 0);
            end
            ready_i = ($urandom_range(0, 2) != 0);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        tick();
        tick();
        tick();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rand_final_drain: got %b expected 0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_none();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_3_to_8_stream.md
Name: dec_3_to_8_stream

Overview:
- Streaming inverse of the 8-to-3 priority encoder: accepts an encoded index plus a "no request" flag and produces the matching one-hot 8-bit vector.
- Registered and elastic: a valid/ready handshake on both sides, with a DEPTH-entry buffer between them.
- Sits downstream of the encoder so a one-hot grant/select can be regenerated, with backpressure, in a different pipeline stage.
- The encoder's "no input active" case (high-Z output) is carried explicitly as none_i and decodes to all-zeros.

Parameters:
- IDX_W, 3, width of the encoded index; output width is OUT_W = 2**IDX_W (8 at default).
- DEPTH, 2, number of buffer entries; legal range 1..16.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream has a word.
- ready_o  output  1  block can accept a word this cycle.
- idx_i  input  IDX_W  encoded index (bit position to set).
- none_i  input  1  no index active; decode to all zeros, idx_i ignored.
- valid_o  output  1  y_o holds a valid decoded word.
- ready_i  input  1  downstream accepts y_o this cycle.
- y_o  output  OUT_W  decoded vector: one-hot, or zero when none.
- count_o  output  $clog2(DEPTH+1)  current buffer occupancy.

Behaviour:
Reset
- rst_i high at a clock edge clears occupancy and the read/write pointers.
- After that edge: valid_o=0, ready_o=1, y_o=0, count_o=0.
- Reset mid-transfer discards all buffered words. No partial state survives.

Handshake and ordering
- Push when valid_i && ready_o. Pop when valid_o && ready_i.
- ready_o = (count < DEPTH). It depends only on registered state, with no combinational path from ready_i.
- valid_o = (count != 0).
- Order is strictly FIFO.

Decoding and output
- Decode happens at push time; the buffer stores OUT_W-bit vectors.
- Stored word = none_i ? 0 : (1 << idx_i).
- y_o is driven from the head entry through the read mux only, with no logic after the mux.
- y_o = 0 whenever valid_o = 0.

Latency and throughput
- A word pushed in cycle N appears on y_o with valid_o=1 in cycle N+1 when the buffer was empty. No same-cycle bypass.
- Throughput is one word per cycle when DEPTH >= 2 and ready_i is held high.

Boundary conditions
- Full (count = DEPTH): ready_o=0, and pushes are refused even if a pop happens in the same cycle.
- Empty with valid_i: the push proceeds and count becomes 1.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two; wrap explicitly at DEPTH-1.
- Stable-output rule: while valid_o=1 and ready_i=0, y_o holds its value.
- Upstream rule (checked by an assertion): while valid_i=1 and ready_o=0, the sender must hold idx_i and none_i stable.

Assertions
- y_o is one-hot or zero at all times.
- count_o <= DEPTH.

Decomposition:
- Package dec_stream_pkg provides:
  - localparam IDX_W_DEF=3.
  - typedef logic [7:0] onehot8_t.
  - function automatic onehot_decode(idx, none) returning the OUT_W vector.
- One sub-module, sync_fifo_flop: a parameterised WIDTH x DEPTH register FIFO with push/pop, full/empty and count.
- The top level holds the decode function plus the handshake glue.

Test Plan:
1. Reset, then idx_i=5, none_i=0, valid_i one cycle with ready_i=1 -> next cycle valid_o=1, y_o=8'b0010_0000; following cycle valid_o=0, y_o=0.
2. none_i=1, idx_i=3, valid_i one cycle -> y_o=8'h00 with valid_o=1 for one cycle.
3. ready_i=0, push idx 1, 2, 3 back-to-back at DEPTH=2 -> ready_o drops after the 2nd push and idx 3 is held; raise ready_i -> y_o sequence 8'h02, 8'h04, 8'h08, then 8'h08 leaves and valid_o falls.
4. Continuous valid_i and ready_i, sweeping idx 0..7 -> one word per cycle, y_o walks 8'h01..8'h80 one cycle behind, count_o stays 1.
5. Fill to DEPTH, then assert rst_i for one cycle mid-stream -> next cycle count_o=0, valid_o=0, y_o=0, ready_o=1; a subsequent push of idx 7 yields y_o=8'h80.
6. Random valid_i/ready_i over 10k cycles against a queue model -> ordering matches, and the stable-output rule and one-hot assertion never fire.
